// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC and reads instructions over the shared bus.
// It feeds the IF pipeline register (IFPC/IFInsn/IFEn) and holds a one-entry stall buffer.
module if_stage #(
  parameter int unsigned       ADDR_W       = 30,
  parameter int unsigned       DATA_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              Stall,
  input  logic              Flush,
  input  logic [ADDR_W-1:0] NewPC,
  input  logic              BrTaken,
  input  logic [ADDR_W-1:0] BrAddr,
  output logic              BusReq_,
  input  logic              BusGrnt_,
  output logic              BusAs_,
  output logic [ADDR_W-1:0] BusAddr,
  input  logic              BusRdy_,
  input  logic [DATA_W-1:0] BusRdData,
  output logic [ADDR_W-1:0] IFPC,
  output logic [DATA_W-1:0] IFInsn,
  output logic              IFEn
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] REQ    = 3'd1;
  localparam logic [2:0] ADDR   = 3'd2;
  localparam logic [2:0] ACCESS = 3'd3;
  localparam logic [2:0] HOLD   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] buf_pc_q, buf_pc_d;
  logic [DATA_W-1:0] buf_insn_q, buf_insn_d;
  logic [ADDR_W-1:0] ifpc_q, ifpc_d;
  logic [DATA_W-1:0] ifinsn_q, ifinsn_d;
  logic              ifen_q, ifen_d;
  logic              discard_q, discard_d;

  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic              rdy;

  // A taken branch is only honoured when decode is not stalled; Flush always wins.
  assign redirect = Flush | (BrTaken & ~Stall);
  assign target   = Flush ? NewPC : BrAddr;
  assign rdy      = ~BusRdy_;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_pc_d   = buf_pc_q;
    buf_insn_d = buf_insn_q;
    ifpc_d     = ifpc_q;
    ifinsn_d   = ifinsn_q;
    ifen_d     = ifen_q;
    discard_d  = discard_q;

    // Default to a bubble whenever the IF register advances; deliveries below override it.
    if (!Stall || Flush) begin
      ifen_d = 1'b0;
    end

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (!BusGrnt_) begin
          state_d = ADDR;
        end
      end
      ADDR: begin
        state_d = ACCESS;
        if (redirect) begin
          discard_d = 1'b1;
        end
      end
      ACCESS: begin
        if (rdy) begin
          if (redirect || discard_q) begin
            discard_d = 1'b0;
            state_d   = ADDR;
          end else if (Stall) begin
            buf_pc_d   = pc_q;
            buf_insn_d = BusRdData;
            pc_d       = pc_q + ADDR_W'(1);
            state_d    = HOLD;
          end else begin
            ifpc_d   = pc_q;
            ifinsn_d = BusRdData;
            ifen_d   = 1'b1;
            pc_d     = pc_q + ADDR_W'(1);
            state_d  = ADDR;
          end
        end else if (redirect) begin
          discard_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          state_d = ADDR;
        end else if (!Stall) begin
          ifpc_d   = buf_pc_q;
          ifinsn_d = buf_insn_q;
          ifen_d   = 1'b1;
          state_d  = ADDR;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redirect) begin
      pc_d = target;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q    <= IDLE;
      pc_q       <= RESET_VECTOR;
      buf_pc_q   <= '0;
      buf_insn_q <= '0;
      ifpc_q     <= '0;
      ifinsn_q   <= '0;
      ifen_q     <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_pc_q   <= buf_pc_d;
      buf_insn_q <= buf_insn_d;
      ifpc_q     <= ifpc_d;
      ifinsn_q   <= ifinsn_d;
      ifen_q     <= ifen_d;
      discard_q  <= discard_d;
    end
  end

  assign BusReq_ = (state_q == IDLE);
  assign BusAs_  = (state_q != ADDR);
  assign BusAddr = pc_q;
  assign IFPC    = ifpc_q;
  assign IFInsn  = ifinsn_q;
  assign IFEn    = ifen_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed cycle table, hand-written corner sequences and a randomized run
// checked by a fetch-stream scoreboard backed by a behavioural memory.
module tb_if_stage;

  localparam logic [29:0] RV = 30'h100;

  logic        clk = 1'b0;
  logic        reset_;
  logic        Stall, Flush, BrTaken;
  logic [29:0] NewPC, BrAddr;
  logic        BusReq_, BusGrnt_, BusAs_, BusRdy_;
  logic [29:0] BusAddr;
  logic [31:0] BusRdData;
  logic [29:0] IFPC;
  logic [31:0] IFInsn;
  logic        IFEn;

  if_stage #(
    .ADDR_W      (30),
    .DATA_W      (32),
    .RESET_VECTOR(RV)
  ) dut (
    .clk      (clk),
    .reset_   (reset_),
    .Stall    (Stall),
    .Flush    (Flush),
    .NewPC    (NewPC),
    .BrTaken  (BrTaken),
    .BrAddr   (BrAddr),
    .BusReq_  (BusReq_),
    .BusGrnt_ (BusGrnt_),
    .BusAs_   (BusAs_),
    .BusAddr  (BusAddr),
    .BusRdy_  (BusRdy_),
    .BusRdData(BusRdData),
    .IFPC     (IFPC),
    .IFInsn   (IFInsn),
    .IFEn     (IFEn)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory model state
  logic        mem_pend = 1'b0;
  logic [29:0] mem_addr = '0;
  int unsigned mem_cnt  = 0;
  int unsigned mem_wait = 0;
  logic        mem_rand = 1'b0;
  logic        spurious = 1'b0;

  // Scoreboard state: next instruction address expected out of IF, next fetch address
  logic [29:0] exp_next, exp_fetch, last_pc;
  logic [31:0] last_insn;
  logic        last_en, last_as;
  int          idle_cnt;

  typedef struct {
    logic        st, fl, br;
    logic [29:0] np, ba;
    int unsigned wt;
    logic        en;
    logic [29:0] ifpc;
    logic        as_n;
    logic [29:0] addr;
    logic        req_n;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] insn_of(input logic [29:0] a);
    return {2'b00, a} ^ 32'hA5A5_0000;
  endfunction

  function automatic vec_t mk(input logic st, input logic fl, input logic br,
                              input logic [29:0] np, input logic [29:0] ba,
                              input int unsigned wt, input logic en, input logic [29:0] ifpc,
                              input logic as_n, input logic [29:0] addr, input logic req_n);
    vec_t v;
    v.st = st; v.fl = fl; v.br = br; v.np = np; v.ba = ba; v.wt = wt;
    v.en = en; v.ifpc = ifpc; v.as_n = as_n; v.addr = addr; v.req_n = req_n;
    return v;
  endfunction

  function automatic logic [29:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(3) == 0) r = 32'h3FFF_FFF0 | 32'($urandom_range(15));
    return r[29:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic model_init();
    exp_next  = RV;
    exp_fetch = RV;
    last_pc   = '0;
    last_insn = '0;
    last_en   = 1'b0;
    last_as   = 1'b1;
    idle_cnt  = 0;
  endtask

  task automatic scoreboard();
    logic        redir;
    logic [29:0] tgt;
    if (!reset_) begin
      model_init();
      return;
    end
    // Inputs still on the wires are the ones the last edge consumed.
    redir = Flush | (BrTaken & ~Stall);
    tgt   = Flush ? NewPC : BrAddr;
    if (redir) begin
      chk("sb_redirect_bubble", {31'd0, IFEn}, 32'd0);
      exp_next  = tgt;
      exp_fetch = tgt;
    end else if (Stall) begin
      chk("sb_stall_hold_pc", {1'b0, IFEn, IFPC}, {1'b0, last_en, last_pc});
      chk("sb_stall_hold_insn", IFInsn, last_insn);
    end else if (IFEn) begin
      chk("sb_deliver_pc", {2'b00, IFPC}, {2'b00, exp_next});
      chk("sb_deliver_insn", IFInsn, insn_of(exp_next));
      exp_next = exp_next + 30'd1;
    end else begin
      chk("sb_bubble_hold_pc", {2'b00, IFPC}, {2'b00, last_pc});
      chk("sb_bubble_hold_insn", IFInsn, last_insn);
    end
    if (!BusAs_) begin
      chk("sb_fetch_addr", {2'b00, BusAddr}, {2'b00, exp_fetch});
      chk("sb_as_width", {31'd0, last_as}, 32'd1);
      exp_fetch = exp_fetch + 30'd1;
    end
    if (IFEn || Stall || BusGrnt_ || redir) idle_cnt = 0;
    else idle_cnt++;
    if (idle_cnt == 41) chk("sb_liveness_idle_cycles", 32'(idle_cnt), 32'd0);
    last_en   = IFEn;
    last_pc   = IFPC;
    last_insn = IFInsn;
    last_as   = BusAs_;
  endtask

  // One cycle: memory responds for the new cycle, then the scoreboard looks at the outputs.
  task automatic tick();
    @(negedge clk);
    BusRdy_   = 1'b1;
    BusRdData = $urandom;
    if (!reset_) begin
      mem_pend = 1'b0;
    end else begin
      if (mem_pend) begin
        if (mem_cnt == 0) begin
          BusRdy_   = 1'b0;
          BusRdData = insn_of(mem_addr);
          mem_pend  = 1'b0;
        end else begin
          mem_cnt--;
        end
      end else if (spurious && $urandom_range(9) == 0) begin
        BusRdy_ = 1'b0;
      end
      if (!BusAs_) begin
        mem_pend = 1'b1;
        mem_addr = BusAddr;
        mem_cnt  = mem_rand ? $urandom_range(3) : mem_wait;
      end
    end
    scoreboard();
  endtask

  task automatic wait_strobe(input int bound, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < bound && !ok; k++) begin
      tick();
      if (!BusAs_) ok = 1'b1;
    end
  endtask

  initial begin
    logic ok;
    vec_t v;
    reset_ = 1'b0; Stall = 1'b0; Flush = 1'b0; BrTaken = 1'b0;
    NewPC = '0; BrAddr = '0; BusGrnt_ = 1'b0; BusRdy_ = 1'b1; BusRdData = '0;

    //         st fl br  np      ba      wt  en  ifpc    as  addr    req
    vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,   0, 0, 30'h0,   1, 30'h100, 1)); // 0
    vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,   0, 0, 30'h0,   1, 30'h100, 0));
    vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,   0, 0, 30'h0,   0, 30'h100, 0));
    vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,   0, 0, 30'h0,   1, 30'h100, 0));
    vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,   0, 1, 30'h100, 0, 30'h101, 0));
    vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,   0, 0, 30'h100, 1, 30'h101, 0)); // 5
    vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,   0, 1, 30'h101, 0, 30'h102, 0));
    vecs.push_back(mk(1, 0, 0, 30'h0,  30'h0,   0, 0, 30'h101, 1, 30'h102, 0));
    vecs.push_back(mk(1, 0, 0, 30'h0,  30'h0,   0, 0, 30'h101, 1, 30'h103, 0));
    vecs.push_back(mk(1, 0, 0, 30'h0,  30'h0,   0, 0, 30'h101, 1, 30'h103, 0));
    vecs.push_back(mk(1, 0, 0, 30'h0,  30'h0,   0, 0, 30'h101, 1, 30'h103, 0)); // 10
    vecs.push_back(mk(1, 0, 0, 30'h0,  30'h0,   0, 0, 30'h101, 1, 30'h103, 0));
    vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,   0, 0, 30'h101, 1, 30'h103, 0));
    vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,   0, 1, 30'h102, 0, 30'h103, 0));
    vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,   0, 0, 30'h102, 1, 30'h103, 0));
    vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,   0, 1, 30'h103, 0, 30'h104, 0)); // 15
    vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,   3, 0, 30'h103, 1, 30'h104, 0));
    vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,   0, 1, 30'h104, 0, 30'h105, 0));
    vecs.push_back(mk(0, 0, 1, 30'h0,  30'h200, 0, 0, 30'h104, 1, 30'h105, 0));
    vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,   0, 0, 30'h104, 1, 30'h200, 0));
    vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,   0, 0, 30'h104, 1, 30'h200, 0)); // 20
    vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,   0, 0, 30'h104, 1, 30'h200, 0));
    vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,   0, 0, 30'h104, 0, 30'h200, 0));
    vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,   0, 0, 30'h104, 1, 30'h200, 0));
    vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,   0, 1, 30'h200, 0, 30'h201, 0));
    vecs.push_back(mk(1, 1, 1, 30'h10, 30'h300, 0, 0, 30'h200, 1, 30'h201, 0)); // 25
    vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,   0, 0, 30'h200, 0, 30'h10,  0));
    vecs.push_back(mk(0, 0, 0, 30'h0,  30'h0,   0, 0, 30'h200, 1, 30'h10,  0));
    vecs.push_back(mk(1, 0, 0, 30'h0,  30'h0,   0, 1, 30'h10,  0, 30'h11,  0));

    tick();
    tick();
    reset_ = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      chk($sformatf("tbl%0d_ifen", i), {31'd0, IFEn}, {31'd0, v.en});
      chk($sformatf("tbl%0d_ifpc", i), {2'b00, IFPC}, {2'b00, v.ifpc});
      chk($sformatf("tbl%0d_ifinsn", i), IFInsn, (v.ifpc == 30'h0) ? 32'h0 : insn_of(v.ifpc));
      chk($sformatf("tbl%0d_busas", i), {31'd0, BusAs_}, {31'd0, v.as_n});
      chk($sformatf("tbl%0d_busaddr", i), {2'b00, BusAddr}, {2'b00, v.addr});
      chk($sformatf("tbl%0d_busreq", i), {31'd0, BusReq_}, {31'd0, v.req_n});
      Stall = v.st; Flush = v.fl; BrTaken = v.br; NewPC = v.np; BrAddr = v.ba;
      mem_wait = v.wt;
      mem_wait = (i == 28) ? 2 : mem_wait;
      tick();
    end

    // Now in ACCESS with the IF register stalled on 0x10: asynchronous reset mid-read.
    chk("pre_reset_ifen", {31'd0, IFEn}, 32'd1);
    reset_ = 1'b0; Stall = 1'b0; mem_wait = 0;
    #1;
    chk("async_rst_ifen", {31'd0, IFEn}, 32'd0);
    chk("async_rst_ifpc", {2'b00, IFPC}, 32'd0);
    chk("async_rst_ifinsn", IFInsn, 32'd0);
    chk("async_rst_busreq", {31'd0, BusReq_}, 32'd1);
    chk("async_rst_busas", {31'd0, BusAs_}, 32'd1);
    chk("async_rst_busaddr", {2'b00, BusAddr}, {2'b00, RV});

    // Grant withheld for four cycles after reset.
    BusGrnt_ = 1'b1;
    tick();
    tick();
    reset_ = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("nogrant%0d_busreq", k), {31'd0, BusReq_}, 32'd0);
      chk($sformatf("nogrant%0d_busas", k), {31'd0, BusAs_}, 32'd1);
      chk($sformatf("nogrant%0d_ifen", k), {31'd0, IFEn}, 32'd0);
    end
    BusGrnt_ = 1'b0;
    tick();
    chk("grant_strobe", {31'd0, BusAs_}, 32'd0);
    chk("grant_addr", {2'b00, BusAddr}, {2'b00, RV});

    // PC wrap: redirect to the top word, the following fetch must be word 0.
    Flush = 1'b1; NewPC = 30'h3FFF_FFFF;
    tick();
    Flush = 1'b0;
    wait_strobe(20, ok);
    chk("wrap_top_strobe", {1'b0, ok, BusAddr}, {2'b01, 30'h3FFF_FFFF});
    wait_strobe(20, ok);
    chk("wrap_next_strobe", {1'b0, ok, BusAddr}, {2'b01, 30'h0});

    // Randomized traffic against the scoreboard.
    mem_rand = 1'b1;
    spurious = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      Stall   = ($urandom_range(3) == 0);
      Flush   = ($urandom_range(24) == 0);
      BrTaken = ($urandom_range(11) == 0);
      NewPC   = rand_addr();
      BrAddr  = rand_addr();
      tick();
    end
    Stall = 1'b0; Flush = 1'b0; BrTaken = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
